pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, ALU result payload width (1..64).
REQ-002 The block SHALL have parameter ADDR_W, default 6, register write address width (1..16).
REQ-003 The block SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port freeze  input  1  global pipeline hold.
REQ-006 The block SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-007 The block SHALL have port in_valid  input  1  upstream payload valid.
REQ-008 The block SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-009 The block SHALL have ports in_data / in_waddr / in_rw / in_halted  input  DATA_W / ADDR_W / 1 / 1  payload.
REQ-010 The block SHALL have port out_valid  output  1  head entry valid.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts head.
REQ-012 The block SHALL have ports out_data / out_waddr / out_rw  output  DATA_W / ADDR_W / 1  head payload.
REQ-013 The block SHALL have port halted_out  output  1  equals out_valid AND head halted bit.
REQ-014 The block SHALL have port stall_cnt  output  16  saturating count of cycles with in_valid=1 and in_ready=0.

Function
REQ-015 Storage SHALL be a 2-entry skid buffer (head, skid), with occupancy states EMPTY(0), ONE(1), FULL(2).
REQ-016 in_ready SHALL be 1 iff freeze=0, flush=0, halt_seen=0, and state!=FULL; it is combinational from registers and these inputs only.
REQ-017 out_valid SHALL be 1 iff state!=EMPTY; out_* SHALL always present the head entry, all payload outputs registered (no in_* to out_* combinational path).
REQ-018 Accept SHALL occur when in_valid AND in_ready; drain SHALL occur when out_valid AND out_ready AND freeze=0 AND flush=0.
REQ-019 EMPTY+accept: payload -> head, state -> ONE; latency in->out is exactly 1 cycle.
REQ-020 ONE+accept, no drain: payload -> skid, state -> FULL.
REQ-021 ONE+accept+drain simultaneously: payload -> head, state stays ONE.
REQ-022 ONE+drain only: state -> EMPTY.
REQ-023 FULL+drain: skid -> head, state -> ONE; no accept possible in FULL.
REQ-024 Payload order SHALL be strictly FIFO; no entry is duplicated or dropped except by flush or reset.
REQ-025 freeze=1 SHALL hold all state, payload and outputs unchanged (stall_cnt still counts).
REQ-026 flush=1 SHALL set state -> EMPTY and halt_seen -> 0 at next edge, overriding freeze, accept and drain.
REQ-027 halt_seen SHALL set when an entry with in_halted=1 is accepted; while set, no further accepts occur; only flush or reset clears it.
REQ-028 An accepted halted entry SHALL still propagate and drain normally; halted_out is 1 while it is head.
REQ-029 stall_cnt SHALL increment each cycle with in_valid=1 and in_ready=0, saturate at 0xFFFF, and be cleared only by reset (not flush).
REQ-030 Payload registers of empty slots SHALL not be observable as valid; their contents are don't-care.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state=EMPTY, halt_seen=0, stall_cnt=0, out_data=0, out_waddr=0, out_rw=0, out_valid=0, halted_out=0.
REQ-032 Reset mid-transfer SHALL discard both entries; the first edge after rst_n rises behaves as EMPTY.

Verification
REQ-033 Streaming: out_ready=1, in_valid=1 for 4 cycles, data 0x11,0x22,0x33,0x44 -> out_data same sequence one cycle later, in_ready stays 1.
REQ-034 Backpressure: out_ready=0, push 0xA1,0xA2 -> FULL, in_ready=0; 3rd valid cycle -> stall_cnt=1; out_ready=1 -> 0xA1 then 0xA2, no loss.
REQ-035 Freeze: FULL with out_ready=1, freeze=1 for 3 cycles -> outputs unchanged, stall_cnt +3 if in_valid=1; release -> drains in order.
REQ-036 Halt: accept in_halted=1 (waddr 0x3F) -> halted_out=1 next cycle, in_ready=0 until flush; flush -> out_valid=0, in_ready=1.
REQ-037 Flush+freeze+accept same cycle in ONE -> next cycle EMPTY, new payload discarded.
REQ-038 Async reset asserted mid-cycle in FULL -> out_valid=0 immediately, stall_cnt=0; DATA_W=32, ADDR_W=5 instance passes REQ-033.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer for the ALU writeback pipe: registered head/skid slots,
// global freeze/flush, sticky halt that blocks further accepts, and a stall counter.
module pipe_skid_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic              in_rw,
  input  logic              in_halted,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_waddr,
  output logic              out_rw,
  output logic              halted_out,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] waddr;
    logic              rw;
    logic              halted;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  logic             halt_seen_q, halt_seen_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  entry_t in_entry;
  logic   accept;
  logic   drain;

  assign in_entry = '{data: in_data, waddr: in_waddr, rw: in_rw, halted: in_halted};

  assign in_ready  = !freeze && !flush && !halt_seen_q && (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready && !freeze && !flush;

  // Next-state and slot updates; freeze needs no explicit hold since it
  // already blocks both accept and drain.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    skid_d      = skid_q;
    halt_seen_d = halt_seen_q;
    stall_cnt_d = stall_cnt_q;

    if (in_valid && !in_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    if (flush) begin
      state_d     = ST_EMPTY;
      halt_seen_d = 1'b0;
    end else begin
      if (accept && in_halted) begin
        halt_seen_d = 1'b1;
      end
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            head_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = ST_FULL;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      halt_seen_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      halt_seen_q <= halt_seen_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_data   = head_q.data;
  assign out_waddr  = head_q.waddr;
  assign out_rw     = head_q.rw;
  assign halted_out = out_valid && head_q.halted;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus random traffic
// against a queue-based reference model; a 32/5-bit instance gets a streaming test.
module tb_pipe_skid_stage;

  logic       clk;
  logic       rst_n;
  logic       freeze;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [5:0] in_waddr;
  logic       in_rw;
  logic       in_halted;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [5:0] out_waddr;
  logic       out_rw;
  logic       halted_out;
  logic [15:0] stall_cnt;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [31:0] w_in_data;
  logic [4:0]  w_in_waddr;
  logic        w_out_valid;
  logic [31:0] w_out_data;
  logic [4:0]  w_out_waddr;
  logic        w_out_rw;
  logic        w_halted_out;
  logic [15:0] w_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [5:0] waddr;
    logic       rw;
    logic       halted;
  } ent_t;

  ent_t        m_q[$];
  logic        m_halt;
  logic [15:0] m_stall;

  pipe_skid_stage u_dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_waddr(in_waddr), .in_rw(in_rw), .in_halted(in_halted),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_waddr(out_waddr), .out_rw(out_rw), .halted_out(halted_out),
    .stall_cnt(stall_cnt)
  );

  pipe_skid_stage #(.DATA_W(32), .ADDR_W(5)) u_wide (
    .clk(clk), .rst_n(rst_n), .freeze(1'b0), .flush(1'b0),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .in_waddr(w_in_waddr), .in_rw(1'b0), .in_halted(1'b0),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data),
    .out_waddr(w_out_waddr), .out_rw(w_out_rw), .halted_out(w_halted_out),
    .stall_cnt(w_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    ent_t h;
    check("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (m_q.size() > 0) begin
      h = m_q[0];
      check("out_data", 64'(out_data), 64'(h.data));
      check("out_waddr", 64'(out_waddr), 64'(h.waddr));
      check("out_rw", 64'(out_rw), 64'(h.rw));
      check("halted_out", 64'(halted_out), 64'(h.halted));
    end else begin
      check("halted_out_idle", 64'(halted_out), 64'(0));
    end
  endtask

  // One clock: drive inputs, check in_ready, advance model, check outputs.
  task automatic step(input logic v, input logic [7:0] d, input logic [5:0] a,
                      input logic rw, input logic h, input logic ordy,
                      input logic frz, input logic fl);
    logic exp_rdy;
    ent_t e;
    in_valid = v; in_data = d; in_waddr = a; in_rw = rw; in_halted = h;
    out_ready = ordy; freeze = frz; flush = fl;
    #1;
    exp_rdy = !frz && !fl && !m_halt && (m_q.size() < 2);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (v && !exp_rdy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (fl) begin
      m_q.delete();
      m_halt = 1'b0;
    end else begin
      if (m_q.size() > 0 && ordy && !frz) void'(m_q.pop_front());
      if (v && exp_rdy) begin
        e.data = d; e.waddr = a; e.rw = rw; e.halted = h;
        m_q.push_back(e);
        if (h) m_halt = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 8'h00, 6'h00, 1'b0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] s0;
    logic [31:0] wv[4];
    wv[0] = 32'h1111_1111; wv[1] = 32'h2222_2222; wv[2] = 32'h3333_3333; wv[3] = 32'h4444_4444;

    rst_n = 1'b0; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_waddr = '0; in_rw = 1'b0; in_halted = 1'b0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_data = '0; w_in_waddr = '0;
    m_halt = 1'b0; m_stall = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_stall", 64'(stall_cnt), 64'(0));
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming
    step(1'b1, 8'h11, 6'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stream_first", 64'(out_data), 64'(8'h11));
    step(1'b1, 8'h22, 6'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h33, 6'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h44, 6'h04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stream_last", 64'(out_data), 64'(8'h44));
    idle(1'b1);

    // Backpressure
    s0 = stall_cnt;
    step(1'b1, 8'hA1, 6'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 6'h06, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 6'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_stall_plus1", 64'(stall_cnt), 64'(s0 + 16'd1));
    idle(1'b1);
    check("bp_head_a2", 64'(out_data), 64'(8'hA2));
    idle(1'b1);

    // Freeze while full
    step(1'b1, 8'hB1, 6'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 6'h09, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    s0 = stall_cnt;
    repeat (3) step(1'b1, 8'hEE, 6'h0A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("frz_stall_plus3", 64'(stall_cnt), 64'(s0 + 16'd3));
    check("frz_head_b1", 64'(out_data), 64'(8'hB1));
    idle(1'b1);
    idle(1'b1);

    // Halt then flush
    step(1'b1, 8'hC1, 6'h3F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("halt_out", 64'(halted_out), 64'(1));
    step(1'b1, 8'hC2, 6'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 6'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);

    // Flush + freeze + accept attempt in ONE
    step(1'b1, 8'hD1, 6'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hD2, 6'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("ffa_empty", 64'(out_valid), 64'(0));

    // Async reset mid-cycle in FULL
    step(1'b1, 8'hE1, 6'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hE2, 6'h14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_stall", 64'(stall_cnt), 64'(0));
    check("arst_out_data", 64'(out_data), 64'(0));
    m_q.delete(); m_halt = 1'b0; m_stall = '0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 6'($urandom), 1'($urandom),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
    end

    // Wide instance streaming
    for (int k = 0; k < 4; k++) begin
      w_in_valid = 1'b1; w_in_data = wv[k]; w_in_waddr = 5'(k);
      #1;
      check("w_in_ready", 64'(w_in_ready), 64'(1));
      @(posedge clk);
      #1;
      check("w_out_valid", 64'(w_out_valid), 64'(1));
      check("w_out_data", 64'(w_out_data), 64'(wv[k]));
    end
    w_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("w_drained", 64'(w_out_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
